// File: rtl/cam_pkg.sv
// Shared encodings for the camera capture path: input modes, FSM states and
// the bit positions of the colour fields in the stored pixel formats.
package cam_pkg;

  typedef enum logic [1:0] {
    ModeRgb565 = 2'd0,
    ModeRgb444 = 2'd1,
    ModeYuv    = 2'd2,
    ModeRsvd   = 2'd3
  } cam_mode_e;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StWaitSof = 2'd1,
    StCapture = 2'd2,
    StDone    = 2'd3
  } cam_state_e;

  // RGB332 field positions
  localparam int unsigned R332Hi = 7;
  localparam int unsigned R332Lo = 5;
  localparam int unsigned G332Hi = 4;
  localparam int unsigned G332Lo = 2;
  localparam int unsigned B332Hi = 1;
  localparam int unsigned B332Lo = 0;

  // RGB444 field positions
  localparam int unsigned R444Hi = 11;
  localparam int unsigned R444Lo = 8;
  localparam int unsigned G444Hi = 7;
  localparam int unsigned G444Lo = 4;
  localparam int unsigned B444Hi = 3;
  localparam int unsigned B444Lo = 0;

endpackage

// File: rtl/cam_pix_pack.sv
// Combinational packer: turns the two camera bytes of one pixel into the
// stored RGB332 (DW=8) or RGB444 (DW=12) word.
module cam_pix_pack
  import cam_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input  logic [1:0]    mode,
  input  logic [7:0]    byte_hi,
  input  logic [7:0]    byte_lo,
  output logic [DW-1:0] pix
);

  if (DW == 12) begin : g_rgb444
    always_comb begin
      pix = '0;
      unique case (cam_mode_e'(mode))
        ModeRgb565: begin
          pix[R444Hi:R444Lo] = byte_hi[7:4];
          pix[G444Hi:G444Lo] = {byte_hi[2:0], byte_lo[7]};
          pix[B444Hi:B444Lo] = byte_lo[4:1];
        end
        ModeRgb444: begin
          pix[R444Hi:R444Lo] = byte_hi[3:0];
          pix[G444Hi:G444Lo] = byte_lo[7:4];
          pix[B444Hi:B444Lo] = byte_lo[3:0];
        end
        ModeYuv: begin
          pix[R444Hi:R444Lo] = byte_hi[7:4];
          pix[G444Hi:G444Lo] = byte_hi[7:4];
          pix[B444Hi:B444Lo] = byte_hi[7:4];
        end
        ModeRsvd: pix = '0;
      endcase
    end
  end else begin : g_rgb332
    logic unused_bits;
    assign unused_bits = ^{byte_hi[4], byte_lo[1:0]};

    always_comb begin
      pix = '0;
      unique case (cam_mode_e'(mode))
        ModeRgb565: begin
          pix[R332Hi:R332Lo] = byte_hi[7:5];
          pix[G332Hi:G332Lo] = byte_hi[2:0];
          pix[B332Hi:B332Lo] = byte_lo[4:3];
        end
        ModeRgb444: begin
          pix[R332Hi:R332Lo] = byte_hi[3:1];
          pix[G332Hi:G332Lo] = byte_lo[7:5];
          pix[B332Hi:B332Lo] = byte_lo[3:2];
        end
        ModeYuv: begin
          pix[R332Hi:R332Lo] = byte_hi[7:5];
          pix[G332Hi:G332Lo] = byte_hi[7:5];
          pix[B332Hi:B332Lo] = byte_hi[7:6];
        end
        ModeRsvd: pix = '0;
      endcase
    end
  end

endmodule

// File: rtl/cam_capture.sv
// Camera frame grabber: syncs to vsync/href, assembles two-byte pixels,
// decimates and crops, and writes them to a frame buffer in raster order.
module cam_capture
  import cam_pkg::*;
#(
  parameter int unsigned CAM_SCREEN_X = 160,
  parameter int unsigned CAM_SCREEN_Y = 120,
  parameter int unsigned AW           = 15,
  parameter int unsigned DW           = 8,
  parameter int unsigned DECIM        = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cam_vsync,
  input  logic          cam_href,
  input  logic [7:0]    cam_data,
  input  logic [1:0]    mode,
  input  logic          cap_en,
  input  logic          snapshot,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  output logic          mem_we,
  output logic          frame_done,
  output logic          short_frame,
  output logic          busy,
  output logic [7:0]    frame_cnt
);

  localparam logic [15:0]   ScrX     = 16'(CAM_SCREEN_X);
  localparam logic [15:0]   ScrY     = 16'(CAM_SCREEN_Y);
  localparam logic [15:0]   DecMask  = 16'(DECIM - 1);
  localparam logic [AW-1:0] LineStep = AW'(CAM_SCREEN_X);

  cam_state_e    state_q;
  logic          vsync_q, href_q, phase_q, snap_hold_q;
  logic [7:0]    byte_hi_q;
  logic [15:0]   src_col_q, src_line_q, out_x_q, out_y_q;
  logic [AW-1:0] line_base_q;
  logic [DW-1:0] pix;
  logic          vsync_fall, vsync_rise, line_keep, pix_keep;

  assign vsync_fall = vsync_q & ~cam_vsync;
  assign vsync_rise = ~vsync_q & cam_vsync;
  assign line_keep  = ((src_line_q & DecMask) == 16'd0) && (out_y_q < ScrY);
  assign pix_keep   = line_keep && ((src_col_q & DecMask) == 16'd0) && (out_x_q < ScrX);

  cam_pix_pack #(
    .DW(DW)
  ) u_pack (
    .mode   (mode),
    .byte_hi(byte_hi_q),
    .byte_lo(cam_data),
    .pix    (pix)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      vsync_q     <= 1'b0;
      href_q      <= 1'b0;
      phase_q     <= 1'b0;
      snap_hold_q <= 1'b0;
      byte_hi_q   <= '0;
      src_col_q   <= '0;
      src_line_q  <= '0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      line_base_q <= '0;
      mem_addr    <= '0;
      mem_data    <= '0;
      mem_we      <= 1'b0;
      frame_done  <= 1'b0;
      short_frame <= 1'b0;
      busy        <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      vsync_q    <= cam_vsync;
      href_q     <= cam_href;
      mem_we     <= 1'b0;
      frame_done <= 1'b0;
      // A finished snapshot stays parked in idle until cap_en is dropped.
      if (!cap_en) snap_hold_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cap_en && !snap_hold_q) begin
            state_q <= StWaitSof;
            busy    <= 1'b1;
          end
        end
        StWaitSof: begin
          if (vsync_fall) begin
            state_q     <= StCapture;
            short_frame <= 1'b0;
            phase_q     <= 1'b0;
            src_col_q   <= '0;
            src_line_q  <= '0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            line_base_q <= '0;
          end
        end
        StCapture: begin
          if (vsync_rise) begin
            state_q    <= StDone;
            busy       <= 1'b0;
            frame_done <= 1'b1;
            frame_cnt  <= frame_cnt + 8'd1;
            if (out_y_q < ScrY) short_frame <= 1'b1;
          end else if (cam_href) begin
            phase_q <= ~phase_q;
            if (!phase_q) begin
              byte_hi_q <= cam_data;
            end else begin
              if (pix_keep) begin
                mem_we   <= 1'b1;
                mem_data <= pix;
                mem_addr <= line_base_q + AW'(out_x_q);
                out_x_q  <= out_x_q + 16'd1;
              end
              if (src_col_q != '1) src_col_q <= src_col_q + 16'd1;
            end
          end else begin
            // Any half-assembled pixel is dropped when href falls.
            phase_q <= 1'b0;
            if (href_q) begin
              src_col_q <= '0;
              out_x_q   <= '0;
              if (line_keep) begin
                out_y_q     <= out_y_q + 16'd1;
                line_base_q <= line_base_q + LineStep;
              end
              if (src_line_q != '1) src_line_q <= src_line_q + 16'd1;
            end
          end
        end
        StDone: begin
          if (snapshot || !cap_en) begin
            state_q     <= StIdle;
            snap_hold_q <= snapshot && cap_en;
          end else begin
            state_q <= StWaitSof;
            busy    <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_capture.sv
// Directed bench for cam_capture: a default 160x120 RGB332 instance and a
// small 8x6 RGB444 instance with 2x decimation, sharing the camera bus.
module tb_cam_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, cam_vsync, cam_href, cap_en_a, cap_en_b, snapshot, mon_clr;
  logic [7:0]  cam_data;
  logic [1:0]  mode;
  logic [14:0] addr_a;
  logic [7:0]  data_a, cnt_a;
  logic        we_a, fd_a, short_a, busy_a;
  logic [5:0]  addr_b;
  logic [11:0] data_b, exp_b;
  logic        we_b, fd_b, short_b, busy_b;
  logic [7:0]  cnt_b;

  int tests = 0;
  int fails = 0;
  int wr_a, last_a, max_a, seq_a, fdc_a, wr_b, last_b, err_b, fdc_b;
  logic [7:0] ldata_a;

  cam_capture u_dut_a (
    .clk(clk), .rst(rst), .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
    .mode(mode), .cap_en(cap_en_a), .snapshot(snapshot), .mem_addr(addr_a), .mem_data(data_a),
    .mem_we(we_a), .frame_done(fd_a), .short_frame(short_a), .busy(busy_a), .frame_cnt(cnt_a)
  );

  cam_capture #(
    .CAM_SCREEN_X(8), .CAM_SCREEN_Y(6), .AW(6), .DW(12), .DECIM(2)
  ) u_dut_b (
    .clk(clk), .rst(rst), .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
    .mode(mode), .cap_en(cap_en_b), .snapshot(snapshot), .mem_addr(addr_b), .mem_data(data_b),
    .mem_we(we_b), .frame_done(fd_b), .short_frame(short_b), .busy(busy_b), .frame_cnt(cnt_b)
  );

  // Instance B keeps source column/line 2k; the pixel's R/G fields carry them.
  assign exp_b = {4'(2 * (wr_b % 8)), 4'(2 * (wr_b / 8)), 4'h0};

  always @(negedge clk) begin
    if (mon_clr) begin
      wr_a <= 0; last_a <= -1; max_a <= 0; seq_a <= 0; fdc_a <= 0; ldata_a <= '0;
      wr_b <= 0; last_b <= -1; err_b <= 0; fdc_b <= 0;
    end else begin
      if (we_a) begin
        if (int'(addr_a) != wr_a) seq_a <= seq_a + 1;
        if (int'(addr_a) > max_a) max_a <= int'(addr_a);
        last_a  <= int'(addr_a);
        ldata_a <= data_a;
        wr_a    <= wr_a + 1;
      end
      if (we_b) begin
        if (int'(addr_b) != wr_b || data_b !== exp_b) err_b <= err_b + 1;
        last_b <= int'(addr_b);
        wr_b   <= wr_b + 1;
      end
      if (fd_a) fdc_a <= fdc_a + 1;
      if (fd_b) fdc_b <= fdc_b + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    @(negedge clk); #1 mon_clr = 1'b1;
    @(negedge clk); #1 mon_clr = 1'b0;
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    cam_href = 1'b1;
    cam_data = b;
  endtask

  task automatic end_line();
    @(negedge clk);
    cam_href = 1'b0;
    cam_data = 8'h00;
    repeat (2) @(negedge clk);
  endtask

  // pat 0: every pixel 0xF8,0x00; pat 1: {0,col},{line,0} for RGB444 input.
  task automatic send_line(input int nb, input int line, input int pat);
    logic [7:0] b;
    for (int i = 0; i < nb; i++) begin
      if (pat == 0) b = (i % 2 == 0) ? 8'hF8 : 8'h00;
      else          b = (i % 2 == 0) ? {4'h0, 4'(i / 2)} : {4'(line), 4'h0};
      send_byte(b);
    end
    end_line();
  endtask

  task automatic frame_begin();
    @(negedge clk);
    cam_vsync = 1'b1;
    repeat (3) @(negedge clk);
    cam_vsync = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic frame_end();
    @(negedge clk);
    cam_vsync = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic pix(input string tag, input logic [1:0] m, input logic [7:0] hi,
                     input logic [7:0] lo, input logic [7:0] exp_d, input int exp_a);
    mode = m;
    send_byte(hi);
    @(posedge clk); #1;
    check({tag, "_we_hi"}, 32'(we_a), 32'd0);
    send_byte(lo);
    @(posedge clk); #1;
    check({tag, "_we"}, 32'(we_a), 32'd1);
    check({tag, "_data"}, 32'(data_a), 32'(exp_d));
    check({tag, "_addr"}, 32'(addr_a), 32'(exp_a));
  endtask

  initial begin
    rst = 1'b0; cam_vsync = 1'b0; cam_href = 1'b0; cam_data = 8'h00; mode = 2'd0;
    cap_en_a = 1'b0; cap_en_b = 1'b0; snapshot = 1'b0; mon_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_addr", 32'(addr_a), 32'd0);
    check("rst_data", 32'(data_a), 32'd0);
    check("rst_we", 32'(we_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_cnt", 32'(cnt_a), 32'd0);
    check("rst_short", 32'(short_a), 32'd0);
    check("rst_fd", 32'(fd_a), 32'd0);
    rst = 1'b1;
    clear_mon();

    // Decimated RGB444 capture on the small instance.
    mode = 2'd1; cap_en_b = 1'b1;
    frame_begin();
    for (int l = 0; l < 12; l++) send_line(32, l, 1);
    cap_en_b = 1'b0;
    frame_end();
    settle();
    check("dec_writes", 32'(wr_b), 32'd48);
    check("dec_last", 32'(last_b), 32'd47);
    check("dec_pixels", 32'(err_b), 32'd0);
    check("dec_fd", 32'(fdc_b), 32'd1);
    check("dec_cnt", 32'(cnt_b), 32'd1);
    check("dec_short", 32'(short_b), 32'd0);
    check("dec_busy", 32'(busy_b), 32'd0);
    check("dec_a_idle", 32'(wr_a), 32'd0);

    // Full 160x120 frame on the default instance.
    clear_mon();
    mode = 2'd0; cap_en_a = 1'b1;
    frame_begin();
    check("full_busy", 32'(busy_a), 32'd1);
    for (int l = 0; l < 120; l++) send_line(320, l, 0);
    frame_end();
    settle();
    check("full_writes", 32'(wr_a), 32'd19200);
    check("full_last", 32'(last_a), 32'd19199);
    check("full_seq", 32'(seq_a), 32'd0);
    check("full_data", 32'(ldata_a), 32'hE0);
    check("full_fd", 32'(fdc_a), 32'd1);
    check("full_cnt", 32'(cnt_a), 32'd1);
    check("full_short", 32'(short_a), 32'd0);
    check("full_rearm", 32'(busy_a), 32'd1);
    check("full_b_off", 32'(wr_b), 32'd0);

    // Directed pixel formats, latency, odd byte and line addressing.
    frame_begin();
    pix("yuv_ff", 2'd2, 8'hFF, 8'h12, 8'hFF, 0);
    pix("rgb565_red", 2'd0, 8'hF8, 8'h00, 8'hE0, 1);
    pix("rgb565_grn", 2'd0, 8'h07, 8'hE0, 8'h1C, 2);
    pix("rgb444", 2'd1, 8'h0A, 8'h50, 8'hA8, 3);
    pix("rsvd", 2'd3, 8'hFF, 8'hFF, 8'h00, 4);
    pix("rgb565_mix", 2'd0, 8'h12, 8'h34, 8'h0A, 5);
    send_byte(8'h55);
    @(posedge clk); #1;
    check("odd_no_we", 32'(we_a), 32'd0);
    end_line();
    check("odd_still_no_we", 32'(we_a), 32'd0);
    pix("line1", 2'd0, 8'hF8, 8'h00, 8'hE0, 160);
    end_line();
    @(negedge clk);
    cam_vsync = 1'b1;
    @(posedge clk); #1;
    check("eof_fd", 32'(fd_a), 32'd1);
    check("eof_cnt", 32'(cnt_a), 32'd2);
    check("eof_short", 32'(short_a), 32'd1);
    check("eof_busy", 32'(busy_a), 32'd0);
    @(posedge clk); #1;
    check("eof_fd_pulse", 32'(fd_a), 32'd0);
    check("eof_rearm", 32'(busy_a), 32'd1);

    // Short frame of 60 lines.
    clear_mon();
    frame_begin();
    check("short_clear", 32'(short_a), 32'd0);
    for (int l = 0; l < 60; l++) send_line(320, l, 0);
    frame_end();
    settle();
    check("short_writes", 32'(wr_a), 32'd9600);
    check("short_last", 32'(last_a), 32'd9599);
    check("short_fd", 32'(fdc_a), 32'd1);
    check("short_flag", 32'(short_a), 32'd1);

    // Over-long lines; cap_en dropped mid-frame must not abort.
    clear_mon();
    frame_begin();
    send_line(400, 0, 0);
    cap_en_a = 1'b0;
    send_line(400, 1, 0);
    send_line(400, 2, 0);
    frame_end();
    settle();
    check("long_writes", 32'(wr_a), 32'd480);
    check("long_max", 32'(max_a), 32'd479);
    check("long_seq", 32'(seq_a), 32'd0);
    check("long_fd", 32'(fdc_a), 32'd1);
    check("long_cnt", 32'(cnt_a), 32'd4);
    check("long_idle", 32'(busy_a), 32'd0);

    // Snapshot: only the first of two frames is taken.
    clear_mon();
    snapshot = 1'b1; cap_en_a = 1'b1;
    frame_begin();
    send_line(8, 0, 0);
    send_line(8, 1, 0);
    frame_end();
    frame_begin();
    send_line(8, 0, 0);
    send_line(8, 1, 0);
    frame_end();
    settle();
    check("snap_fd", 32'(fdc_a), 32'd1);
    check("snap_writes", 32'(wr_a), 32'd8);
    check("snap_cnt", 32'(cnt_a), 32'd5);
    check("snap_idle", 32'(busy_a), 32'd0);

    // Asynchronous reset in the middle of a line.
    snapshot = 1'b0; cap_en_a = 1'b0;
    repeat (2) @(negedge clk);
    cap_en_a = 1'b1;
    frame_begin();
    send_line(320, 0, 0);
    for (int i = 0; i < 6; i++) send_byte((i % 2 == 0) ? 8'hF8 : 8'h00);
    @(posedge clk); #2 rst = 1'b0; #1;
    check("mrst_we", 32'(we_a), 32'd0);
    check("mrst_addr", 32'(addr_a), 32'd0);
    check("mrst_data", 32'(data_a), 32'd0);
    check("mrst_busy", 32'(busy_a), 32'd0);
    check("mrst_cnt", 32'(cnt_a), 32'd0);
    check("mrst_fd", 32'(fd_a), 32'd0);
    check("mrst_short", 32'(short_a), 32'd0);
    @(negedge clk);
    cam_href = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    clear_mon();
    send_line(320, 1, 0);
    send_line(320, 2, 0);
    settle();
    check("mrst_no_we", 32'(wr_a), 32'd0);
    check("mrst_wait", 32'(busy_a), 32'd1);
    frame_begin();
    send_line(320, 0, 0);
    frame_end();
    settle();
    check("mrst_resume_writes", 32'(wr_a), 32'd160);
    check("mrst_resume_seq", 32'(seq_a), 32'd0);
    check("mrst_resume_cnt", 32'(cnt_a), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
